// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet layer sequencer.
// Contents: FSM state encoding, layer index constants, default layer count and a small helper.
package lenet_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RUN  = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int L_CONV1 = 0;
  localparam int L_POOL1 = 1;
  localparam int L_CONV2 = 2;
  localparam int L_POOL2 = 3;
  localparam int L_FC1   = 4;
  localparam int L_FC2   = 5;

  localparam int LENET_NUM_LAYERS = 6;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lenet_wdog.sv
// Run-cycle watchdog for the layer sequencer; only instantiated when LAYER_WDOG_EN is defined.
// Counts enabled cycles and flags expiry on the LIMIT-th one.
module lenet_wdog #(
  parameter int LIMIT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_reg, count_next;

  // Expiry is combinational so the sequencer can leave RUN on the LIMIT-th cycle.
  assign expired = en && !clr && (count_reg == CW'(LIMIT - 1));

  always_comb begin
    count_next = count_reg;
    if (clr)
      count_next = '0;
    else if (en && !expired)
      count_next = count_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count_reg <= '0;
    else
      count_reg <= count_next;
  end

endmodule

// File: rtl/lenet_layer_sched.sv
// Layer sequencer: enables each LeNet layer in turn with a finish mask after arming and a low gap.
// Optional per-layer RUN watchdog is built when LAYER_WDOG_EN is defined.
module lenet_layer_sched
  import lenet_pkg::*;
#(
  parameter int NUM_LAYERS = LENET_NUM_LAYERS,
  parameter int ARM_CYCLES = 2,
  parameter int GAP_CYCLES = 2,
  parameter int WDOG_LIMIT = 65535,
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] layer_finish,
  output logic [NUM_LAYERS-1:0] layer_en,
  output logic [LW-1:0]         cur_layer,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           frame_cnt,
  output logic                  err_timeout
);

  localparam int CW = $clog2(max2(ARM_CYCLES, GAP_CYCLES) + 1);

  state_t                state_reg, state_next;
  logic [LW-1:0]         cur_reg, cur_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [NUM_LAYERS-1:0] layer_en_reg, layer_en_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic [15:0]           frame_cnt_reg, frame_cnt_next;
  logic                  run_next;
  logic                  finish_sel;
  logic                  wdog_expired;

  // In RUN the enable register is one-hot on the current layer, so it doubles as the finish select.
  assign finish_sel = |(layer_finish & layer_en_reg);

`ifdef LAYER_WDOG_EN
  logic err_reg, err_next;

  lenet_wdog #(
    .LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_reg != S_RUN),
    .en      (state_reg == S_RUN),
    .expired (wdog_expired)
  );

  always_comb begin
    err_next = err_reg;
    if (!abort && state_reg == S_IDLE && start)
      err_next = 1'b0;
    else if (!abort && state_reg == S_RUN && wdog_expired)
      err_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err_reg <= 1'b0;
    else
      err_reg <= err_next;
  end

  assign err_timeout = err_reg;
`else
  assign wdog_expired = 1'b0;
  assign err_timeout  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      cur_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cur_reg   <= cur_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    cnt_next   = cnt_reg;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_next = S_ARM;
            cur_next   = '0;
            cnt_next   = '0;
          end
        end
        S_ARM: begin
          if (cnt_reg == CW'(ARM_CYCLES - 1)) begin
            state_next = S_RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        S_RUN: begin
          if (wdog_expired) begin
            state_next = S_IDLE;
          end else if (finish_sel) begin
            state_next = S_GAP;
            cnt_next   = '0;
          end
        end
        S_GAP: begin
          if (cnt_reg == CW'(GAP_CYCLES - 1)) begin
            cnt_next = '0;
            if (cur_reg == LW'(NUM_LAYERS - 1)) begin
              state_next = S_DONE;
            end else begin
              cur_next   = cur_reg + 1'b1;
              state_next = S_ARM;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Outputs are precomputed from the next state so every port comes straight from a flop.
  always_comb begin
    run_next       = (state_next == S_ARM) || (state_next == S_RUN);
    busy_next      = (state_next != S_IDLE);
    done_next      = (state_next == S_DONE);
    frame_cnt_next = frame_cnt_reg;
    if (state_reg == S_DONE && !abort)
      frame_cnt_next = frame_cnt_reg + 16'd1;
  end

  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_en
      assign layer_en_next[gi] = run_next && (cur_next == LW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      layer_en_reg  <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      layer_en_reg  <= layer_en_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  assign layer_en  = layer_en_reg;
  assign cur_layer = cur_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_lenet_layer_sched.sv
// Self-checking bench for lenet_layer_sched: reactive layer models plus a per-frame schedule model.
// Watchdog scenario is included when LAYER_WDOG_EN is defined.
module tb_lenet_layer_sched;

  localparam int NL   = 6;
  localparam int ARM  = 2;
  localparam int GAP  = 2;
  localparam int WDOG = 100;
  localparam int BIG  = 1_000_000_000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NL-1:0] layer_finish = '0;
  logic [NL-1:0] layer_en;
  logic [2:0]    cur_layer;
  logic          busy;
  logic          done;
  logic [15:0]   frame_cnt;
  logic          err_timeout;

  always #5 clk = ~clk;

  lenet_layer_sched #(
    .NUM_LAYERS (NL),
    .ARM_CYCLES (ARM),
    .GAP_CYCLES (GAP),
    .WDOG_LIMIT (WDOG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .layer_finish (layer_finish),
    .layer_en     (layer_en),
    .cur_layer    (cur_layer),
    .busy         (busy),
    .done         (done),
    .frame_cnt    (frame_cnt),
    .err_timeout  (err_timeout)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Layer models: finish rises d_lat cycles after the layer sees its enable rise, then holds.
  int            d_lat[NL];
  int            seen_rise[NL];
  logic [NL-1:0] en_prev = '0;
  bit            stale = 1'b0;
  int            hang_layer = -1;

  // Expected frame schedule, in absolute cycle numbers.
  int s_cyc = BIG;
  int exp_rise[NL];
  int exp_fall[NL];
  int exp_done = BIG;
  int end_cyc = BIG;
  int abort_cyc = BIG;
  int stray_cyc = BIG;
  int to_layer = -1;
  int exp_frames = 0;
  int exp_cur = 0;
  bit exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    logic [NL-1:0] ee;
    bit live;
    bit exp_busy;
    bit exp_done_b;
    @(posedge clk);
    #1;
    cyc++;
    live = (cyc <= abort_cyc);
    ee = '0;
    for (int k = 0; k < NL; k++) begin
      if (live && cyc >= exp_rise[k] && cyc < exp_fall[k]) ee[k] = 1'b1;
      if (live && cyc == exp_rise[k]) exp_cur = k;
    end
    if (cyc == s_cyc + 1) exp_err = 1'b0;
    if (to_layer >= 0 && live && cyc == exp_fall[to_layer]) exp_err = 1'b1;
    if (cyc == exp_done + 1 && exp_done <= abort_cyc) exp_frames = (exp_frames + 1) % 65536;
    exp_busy   = live && cyc > s_cyc && cyc < end_cyc;
    exp_done_b = live && cyc == exp_done;

    chk("layer_en", 32'(layer_en), 32'(ee));
    chk("en_onehot", ($countones(layer_en) <= 1) ? 32'd1 : 32'd0, 32'd1);
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done_b));
    chk("cur_layer", 32'(cur_layer), 32'(exp_cur));
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    chk("err_timeout", 32'(err_timeout), 32'(exp_err));

    for (int k = 0; k < NL; k++) begin
      if (layer_en[k] && !en_prev[k]) seen_rise[k] = cyc;
      if (stale)
        layer_finish[k] = 1'b1;
      else if (k == hang_layer && seen_rise[k] >= s_cyc)
        layer_finish[k] = 1'b0;
      else
        layer_finish[k] = (seen_rise[k] >= 0) && (cyc >= seen_rise[k] + d_lat[k]);
    end
    en_prev = layer_en;

    start = 1'b0;
    abort = 1'b0;
    if (cyc == stray_cyc) start = 1'b1;
    if (cyc == abort_cyc) abort = 1'b1;
  endtask

  task automatic randomize_lat();
    for (int k = 0; k < NL; k++) d_lat[k] = int'($urandom_range(1, 14));
  endtask

  // Starts a frame in the current cycle and runs until it has settled, checking every cycle.
  task automatic run_frame(input bit st, input int abort_layer, input int stray_layer, input int hang);
    int t;
    int lat;
    int stop;
    stale      = st;
    hang_layer = hang;
    to_layer   = hang;
    s_cyc      = cyc;
    for (int k = 0; k < NL; k++) begin
      exp_rise[k] = BIG;
      exp_fall[k] = BIG;
    end
    exp_done = BIG;
    end_cyc  = BIG;
    t = s_cyc + 1;
    for (int k = 0; k < NL; k++) begin
      exp_rise[k] = t;
      if (k == hang) begin
        exp_fall[k] = t + ARM + WDOG;
        end_cyc     = exp_fall[k];
        break;
      end
      lat = st ? 0 : d_lat[k];
      exp_fall[k] = t + ((lat > ARM) ? lat : ARM) + 1;
      t = exp_fall[k] + GAP;
    end
    if (hang < 0) begin
      exp_done = t;
      end_cyc  = t + 1;
    end
    abort_cyc = (abort_layer >= 0) ? exp_rise[abort_layer] + 1 : BIG;
    stray_cyc = (stray_layer >= 0) ? exp_rise[stray_layer] + 2 : BIG;
    start = 1'b1;
    stop = (abort_cyc < BIG) ? abort_cyc + 1 : end_cyc;
    while (cyc < stop + 3) tick();
    s_cyc = BIG;
    abort_cyc = BIG;
    stray_cyc = BIG;
    to_layer = -1;
    hang_layer = -1;
    exp_done = BIG;
    end_cyc = BIG;
    for (int k = 0; k < NL; k++) begin
      exp_rise[k] = BIG;
      exp_fall[k] = BIG;
    end
  endtask

  initial begin
    for (int k = 0; k < NL; k++) begin
      d_lat[k]     = 10;
      seen_rise[k] = -1;
      exp_rise[k]  = BIG;
      exp_fall[k]  = BIG;
    end

    repeat (3) tick();
    rst = 1'b1;
    tick();
    tick();

    // Normal frame: each finish 10 cycles after its enable.
    run_frame(1'b0, -1, -1, -1);
    chk("frames_after_normal", 32'(frame_cnt), 32'd1);

    // All finish flags held high: only the arm mask paces the layers.
    run_frame(1'b1, -1, -1, -1);

    // Start pulse while layer 3 is active must be ignored.
    randomize_lat();
    run_frame(1'b0, -1, 3, -1);

    // Abort while layer 2 is enabled, then a clean frame from layer 0.
    randomize_lat();
    run_frame(1'b0, 2, -1, -1);
    chk("abort_cur", 32'(cur_layer), 32'd2);
    chk("abort_busy", 32'(busy), 32'd0);
    randomize_lat();
    run_frame(1'b0, -1, -1, -1);

    repeat (3) begin
      randomize_lat();
      run_frame(1'b0, -1, -1, -1);
    end

    // Frame counter wrap.
    exp_frames = 65535;
    force dut.frame_cnt_reg = 16'hFFFF;
    tick();
    tick();
    release dut.frame_cnt_reg;
    tick();
    run_frame(1'b1, -1, -1, -1);
    chk("frame_wrap", 32'(frame_cnt), 32'd0);

`ifdef LAYER_WDOG_EN
    // Layer 4 never finishes: watchdog must end the frame without done.
    randomize_lat();
    run_frame(1'b0, -1, -1, 4);
    chk("wdog_err", 32'(err_timeout), 32'd1);
    chk("wdog_cur", 32'(cur_layer), 32'd4);
    randomize_lat();
    run_frame(1'b0, -1, -1, -1);
    chk("wdog_err_cleared", 32'(err_timeout), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
